// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its skid buffer.
package pipe_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry output/skid buffer: state counts held payloads, ready is registered
// so upstream never sees a combinational path from downstream ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned         WIDTH     = 166,
    parameter logic [0:WIDTH-1]    NOP_VALUE = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [0:WIDTH-1]   data_i,
    input  logic               pop_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [0:WIDTH-1]   data_o
);

    skid_state_e        state_q;
    logic [0:WIDTH-1]   out_q;
    logic [0:WIDTH-1]   skid_q;
    logic               ready_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state_q <= EMPTY;
            out_q   <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        state_q <= ONE;
                        out_q   <= data_i;
                    end
                end
                ONE: begin
                    if (push_i && pop_i) begin
                        out_q <= data_i;
                    end else if (push_i) begin
                        state_q <= TWO;
                        skid_q  <= data_i;
                        ready_q <= 1'b0;
                    end else if (pop_i) begin
                        state_q <= EMPTY;
                        out_q   <= NOP_VALUE;
                    end
                end
                TWO: begin
                    // Older payload leaves; the skid entry becomes the head.
                    if (pop_i) begin
                        state_q <= ONE;
                        out_q   <= skid_q;
                        skid_q  <= NOP_VALUE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    out_q   <= NOP_VALUE;
                    skid_q  <= NOP_VALUE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (state_q != EMPTY);
    assign data_o  = out_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN to add a registered-ready skid entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         WIDTH     = 166,
    parameter logic [0:WIDTH-1]    NOP_VALUE = '0,
    parameter int unsigned         CNT_W     = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:WIDTH-1]   in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:WIDTH-1]   out_data,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic skid_ready;

    pipe_skid_buf #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .clk_i     (clk),
        .reset_i   (reset),
        .flush_i   (flush),
        .push_i    (accept),
        .data_i    (in_data),
        .pop_i     (emit),
        .ready_o   (skid_ready),
        .valid_o   (out_valid),
        .data_o    (out_data)
    );

    assign in_ready = skid_ready && !flush && !reset;
`else
    logic               valid_q;
    logic [0:WIDTH-1]   data_q;

    assign in_ready = (!valid_q || out_ready) && !flush && !reset;

    // Single entry: accept wins over emit, giving pass-through on simultaneous handshakes.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (emit) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
`endif

    logic [CNT_W-1:0] stall_q;

    // Saturating back-pressure counter; flush deliberately does not touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;

endmodule
